// File: rtl/store_drain_ctrl_if.sv
// rtl/store_drain_ctrl_if.sv - D-cache store write request port between drain controller and cache
interface store_drain_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              dcache_req_valid;
    logic [ADDR_W-1:0] dcache_req_addr;
    logic [DATA_W-1:0] dcache_req_data;
    logic [1:0]        dcache_req_size;
    logic              dcache_req_ready;

    modport master (
        output dcache_req_valid,
        output dcache_req_addr,
        output dcache_req_data,
        output dcache_req_size,
        input  dcache_req_ready
    );

    modport slave (
        input  dcache_req_valid,
        input  dcache_req_addr,
        input  dcache_req_data,
        input  dcache_req_size,
        output dcache_req_ready
    );
endinterface

// File: rtl/store_drain_ctrl.sv
// rtl/store_drain_ctrl.sv - drains committed stores from the SQ head into the shared D-cache port
module store_drain_ctrl #(
    parameter int SQ_DEPTH     = 8,
    parameter int N            = 2,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int HIGH_WATER   = 4,
    parameter int STARVE_LIMIT = 7,
    localparam int RET_W       = $clog2(N + 1),
    localparam int PEND_W      = $clog2(SQ_DEPTH + 1),
    localparam int STARVE_W    = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [RET_W-1:0]    retire_store_count,
    input  logic                sq_head_valid,
    input  logic [ADDR_W-1:0]   sq_head_addr,
    input  logic [DATA_W-1:0]   sq_head_data,
    input  logic [1:0]          sq_head_size,
    input  logic                load_req_valid,
    output logic                load_grant,
    store_drain_ctrl_if.master  dcache,
    output logic [RET_W-1:0]    sq_free_count,
    output logic [PEND_W-1:0]   pending_stores,
    output logic                drained
);
    typedef enum logic [1:0] {IDLE, REQ, FREE} state_t;

    state_t              state_q, state_d;
    logic [PEND_W-1:0]   pending_q, pending_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [1:0]          size_q;
    logic                latch_head;
    logic                store_wants;
    logic                store_prio;
    logic                store_take;
    logic                handshake;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        latch_head  = 1'b0;
        store_wants = (pending_q != '0) && sq_head_valid && (state_q == IDLE);
        store_prio  = (pending_q >= PEND_W'(HIGH_WATER)) ||
                      (starve_q >= STARVE_W'(STARVE_LIMIT));
        store_take  = store_wants && (!load_req_valid || store_prio);
        handshake   = (state_q == REQ) && dcache.dcache_req_ready;
        // Retire and completion may land in the same cycle; both apply.
        pending_d   = pending_q + PEND_W'(retire_store_count) - PEND_W'(handshake);

        case (state_q)
            IDLE: begin
                if (store_take) begin
                    state_d    = REQ;
                    latch_head = 1'b1;
                    starve_d   = '0;
                end else if (store_wants && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
                    starve_d = starve_q + STARVE_W'(1);
                end
            end
            REQ: begin
                if (handshake) state_d = FREE;
            end
            FREE: begin
                // SQ head advances at the end of this cycle; next head seen in IDLE.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            starve_q  <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            size_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            starve_q  <= starve_d;
            if (latch_head) begin
                addr_q <= sq_head_addr;
                data_q <= sq_head_data;
                size_q <= sq_head_size;
            end
        end
    end

    assign dcache.dcache_req_valid = (state_q == REQ);
    assign dcache.dcache_req_addr  = addr_q;
    assign dcache.dcache_req_data  = data_q;
    assign dcache.dcache_req_size  = size_q;

    assign load_grant     = load_req_valid && (state_q != REQ) && !store_take;
    assign sq_free_count  = RET_W'(state_q == FREE);
    assign pending_stores = pending_q;
    assign drained        = (pending_q == '0) && (state_q == IDLE);
endmodule

// File: tb/tb_store_drain_ctrl.sv
// tb/tb_store_drain_ctrl.sv - self-checking bench for store_drain_ctrl
module tb_store_drain_ctrl;
    localparam int SQ_DEPTH = 8;
    localparam int HIGH_WATER = 4;
    localparam int STARVE_LIMIT = 7;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  retire_store_count = '0;
    logic        sq_head_valid = 1'b0;
    logic [31:0] sq_head_addr = '0;
    logic [31:0] sq_head_data = '0;
    logic [1:0]  sq_head_size = '0;
    logic        load_req_valid = 1'b0;
    logic        load_grant;
    logic [1:0]  sq_free_count;
    logic [3:0]  pending_stores;
    logic        drained;

    store_drain_ctrl_if #(.ADDR_W(32), .DATA_W(32)) dc ();

    store_drain_ctrl dut (
        .clock              (clock),
        .reset              (reset),
        .retire_store_count (retire_store_count),
        .sq_head_valid      (sq_head_valid),
        .sq_head_addr       (sq_head_addr),
        .sq_head_data       (sq_head_data),
        .sq_head_size       (sq_head_size),
        .load_req_valid     (load_req_valid),
        .load_grant         (load_grant),
        .dcache             (dc),
        .sq_free_count      (sq_free_count),
        .pending_stores     (pending_stores),
        .drained            (drained)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Behavioural model: phase 0 = no write outstanding, 1 = write offered, 2 = free pulse.
    int          m_phase = 0;
    int          m_pend = 0;
    int          m_starve = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;
    logic [1:0]  m_size = '0;

    function automatic bit m_take();
        bit wants;
        wants = (m_pend > 0) && sq_head_valid && (m_phase == 0);
        return wants && (!load_req_valid || m_pend >= HIGH_WATER || m_starve >= STARVE_LIMIT);
    endfunction

    always @(posedge clock) begin
        bit t, hs, wants;
        if (reset) begin
            m_phase = 0; m_pend = 0; m_starve = 0;
            m_addr = '0; m_data = '0; m_size = '0;
        end else begin
            wants = (m_pend > 0) && sq_head_valid && (m_phase == 0);
            t = m_take();
            hs = (m_phase == 1) && dc.dcache_req_ready;
            if (t) begin
                m_addr = sq_head_addr; m_data = sq_head_data; m_size = sq_head_size;
                m_starve = 0;
            end else if (wants && m_starve < STARVE_LIMIT) begin
                m_starve = m_starve + 1;
            end
            m_pend = m_pend + int'(retire_store_count) - int'(hs);
            if (m_pend > SQ_DEPTH) begin
                errors++;
                $display("FAIL pend_bound: got %0d expected <= %0d", m_pend, SQ_DEPTH);
            end
            if (m_phase == 0 && t) m_phase = 1;
            else if (m_phase == 1 && hs) m_phase = 2;
            else if (m_phase == 2) m_phase = 0;
        end
    end

    always @(negedge clock) begin
        if (run_cmp) begin
            chk("m_valid", dc.dcache_req_valid, m_phase == 1);
            chk("m_grant", load_grant, load_req_valid && m_phase != 1 && !m_take());
            chk("m_free", sq_free_count, (m_phase == 2) ? 1 : 0);
            chk("m_pending", pending_stores, m_pend);
            chk("m_drained", drained, m_pend == 0 && m_phase == 0);
            if (m_phase == 1) begin
                chk("m_addr", dc.dcache_req_addr, m_addr);
                chk("m_data", dc.dcache_req_data, m_data);
                chk("m_size", dc.dcache_req_size, m_size);
            end
        end
    end

    initial begin
        int  gcnt;
        int  fcnt;
        bit  found;
        dc.dcache_req_ready = 1'b0;
        cyc();
        run_cmp = 1'b1;
        cyc();
        @(negedge clock);
        chk("rst_drained", drained, 1);
        chk("rst_valid", dc.dcache_req_valid, 0);
        chk("rst_addr", dc.dcache_req_addr, 0);
        chk("rst_free", sq_free_count, 0);
        chk("rst_pending", pending_stores, 0);
        chk("rst_grant", load_grant, 0);

        // Single store, ready always high
        cyc();
        reset = 1'b0;
        dc.dcache_req_ready = 1'b1;
        sq_head_valid = 1'b1; sq_head_addr = 32'h100; sq_head_data = 32'hDEAD; sq_head_size = 2'd2;
        retire_store_count = 2'd1;
        cyc(); retire_store_count = 2'd0;
        cyc();
        @(negedge clock);
        chk("t1_valid", dc.dcache_req_valid, 1);
        chk("t1_addr", dc.dcache_req_addr, 32'h100);
        chk("t1_data", dc.dcache_req_data, 32'hDEAD);
        chk("t1_size", dc.dcache_req_size, 2);
        cyc();
        @(negedge clock);
        chk("t1_free", sq_free_count, 1);
        chk("t1_pend0", pending_stores, 0);
        cyc();
        @(negedge clock);
        chk("t1_drained", drained, 1);

        // Two stores with ready stalled for 5 cycles
        cyc();
        dc.dcache_req_ready = 1'b0;
        sq_head_addr = 32'h200; sq_head_data = 32'h1111; sq_head_size = 2'd1;
        retire_store_count = 2'd2;
        cyc(); retire_store_count = 2'd0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("t2_hold_valid", dc.dcache_req_valid, 1);
            chk("t2_hold_addr", dc.dcache_req_addr, 32'h200);
            chk("t2_hold_data", dc.dcache_req_data, 32'h1111);
            chk("t2_hold_pend", pending_stores, 2);
            cyc();
        end
        dc.dcache_req_ready = 1'b1;
        cyc();
        sq_head_addr = 32'h204; sq_head_data = 32'h2222; sq_head_size = 2'd0;
        @(negedge clock);
        chk("t2_free1", sq_free_count, 1);
        chk("t2_pend1", pending_stores, 1);
        cyc(); cyc();
        @(negedge clock);
        chk("t2_addr2", dc.dcache_req_addr, 32'h204);
        chk("t2_data2", dc.dcache_req_data, 32'h2222);
        cyc();
        @(negedge clock);
        chk("t2_free2", sq_free_count, 1);
        chk("t2_pend0", pending_stores, 0);
        cyc();

        // Starvation: two rounds prove the loss counter restarts after a win
        load_req_valid = 1'b1;
        sq_head_addr = 32'h300; sq_head_data = 32'h3333;
        for (int r = 0; r < 2; r++) begin
            retire_store_count = 2'd1;
            cyc(); retire_store_count = 2'd0;
            gcnt = 0; found = 1'b0;
            for (int i = 0; i < 30 && !found; i++) begin
                @(negedge clock);
                if (dc.dcache_req_valid) found = 1'b1;
                else if (load_grant) gcnt++;
                if (!found) cyc();
            end
            chk("t3_store_won", found, 1);
            chk("t3_grant_cycles", gcnt, STARVE_LIMIT);
            chk("t3_req_no_grant", load_grant, 0);
            cyc(); cyc();
        end

        // High-water: store wins on its first eligible cycle despite a load
        sq_head_valid = 1'b0;
        retire_store_count = 2'd2;
        cyc();
        cyc();
        retire_store_count = 2'd0;
        sq_head_valid = 1'b1; sq_head_addr = 32'h400;
        @(negedge clock);
        chk("t4_pend4", pending_stores, 4);
        chk("t4_no_grant", load_grant, 0);
        cyc();
        @(negedge clock);
        chk("t4_valid", dc.dcache_req_valid, 1);
        load_req_valid = 1'b0;
        fcnt = 0; found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            @(negedge clock);
            if (sq_free_count == 2'd1) fcnt++;
            if (drained) found = 1'b1;
        end
        chk("t4_drained", found, 1);
        chk("t4_free_pulses", fcnt, 4);

        // Retire coincides with handshake
        cyc();
        dc.dcache_req_ready = 1'b0;
        sq_head_addr = 32'h500;
        retire_store_count = 2'd1;
        cyc(); retire_store_count = 2'd0;
        cyc();
        dc.dcache_req_ready = 1'b1;
        retire_store_count = 2'd1;
        @(negedge clock);
        chk("t5_valid", dc.dcache_req_valid, 1);
        cyc(); retire_store_count = 2'd0;
        @(negedge clock);
        chk("t5_pend_stays", pending_stores, 1);
        chk("t5_free", sq_free_count, 1);
        cyc(); cyc();
        @(negedge clock);
        chk("t5_reissue", dc.dcache_req_valid, 1);
        cyc(); cyc();

        // Reset while a request is outstanding
        dc.dcache_req_ready = 1'b0;
        retire_store_count = 2'd1;
        cyc(); retire_store_count = 2'd0;
        cyc();
        @(negedge clock);
        chk("t6_valid_before", dc.dcache_req_valid, 1);
        cyc();
        reset = 1'b1;
        cyc();
        @(negedge clock);
        chk("t6_valid", dc.dcache_req_valid, 0);
        chk("t6_pend", pending_stores, 0);
        chk("t6_free", sq_free_count, 0);
        chk("t6_drained", drained, 1);
        cyc();
        reset = 1'b0;
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
